vit_bmu_acs: RTL and testbench
==============================

// Module: vit_bmu_acs
// PURPOSE
//  Decoder front stage that pairs with the (2,1,3) convolutional encoder (K=4, 8-state trellis).
//  - Takes one 2-bit hard-decision channel symbol per valid cycle.
//  - Computes Hamming branch metrics.
//  - Runs add-compare-select on all 8 states and updates the path metrics.
//  - Emits per-step survivor decision bits and the best state to the downstream traceback unit.
// PARAMETERS
//  PM_W      6   path-metric width (bits); normalisation threshold is 2^(PM_W-1)
//  INIT_PM  16   initial metric for states 1..7 at reset/frame_start (state 0 starts at 0)
// PORTS
//  clock        in   1     system clock, all state updates on posedge
//  reset        in   1     synchronous, active-high
//  in_valid     in   1     in_sym valid this cycle
//  in_sym       in   2     received symbol {v1,v0}, same bit order as encoder Vx
//  frame_start  in   1     re-initialise path metrics (qualified by nothing; may coincide with in_valid)
//  out_valid    out  1     decision vector valid
//  out_dec      out  8     survivor bit per next-state n: 0 = pred {n[1],n[0],0}, 1 = pred {n[1],n[0],1}
//  out_best     out  3     state index holding minimum new path metric
//  out_pm_best  out  PM_W  that minimum metric (post-normalisation)
//  out_norm     out  1     normalisation applied on this step (pulse with out_valid)
// BEHAVIOUR
//  Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
//  Trellis convention:
//  - State s = {u[t-1],u[t-2],u[t-3]}.
//  - Input u moves s to next state {u,s[2],s[1]}.
//  - Branch output: v1 = u^s[1]^s[0]; v0 = u^s[2]^s[1]^s[0].
//  - Next state n has predecessors {n[1],n[0],x}, x in {0,1}; input u = n[2].
//  Branch metric: BM = popcount(in_sym ^ {v1,v0}); range 0..2, zero-extended to PM_W.
//  ACS for each n:
//  - cand_x = PM[pred_x] + BM_x.
//  - Select x=1 only when cand_1 < cand_0 (ties pick x=0).
//  - dec[n] = x.
//  Normalisation (same cycle):
//  - If all 8 selected metrics have MSB=1, clear the MSB of every metric and assert out_norm.
//  - Hamming spread <= 6, so there is no overflow or saturation with PM_W >= 5.
//  Best state: minimum of the 8 post-normalisation metrics; ties go to the lowest index.
//  Timing:
//  - Latency 1. in_valid at edge t gives PM updated and out_valid=1 with out_dec/out_best/out_pm_best/out_norm at t+1.
//  - Fully pipelined: one symbol per cycle sustained.
//  - No backpressure; downstream must accept every out_valid.
//  in_valid=0: PM hold; next cycle out_valid=0, out_norm=0; out_dec/out_best/out_pm_best hold their last values.
//  frame_start=1: PM loaded {0,INIT_PM x7}.
//  - If in_valid=1 the same cycle, ACS uses the re-initialised metrics (not the stale ones).
//  - Result is valid at t+1 as normal.
//  reset=1: overrides frame_start and in_valid.
//  - PM = {0,INIT_PM x7}.
//  - out_valid=0, out_dec=0, out_best=0, out_pm_best=0, out_norm=0.
//  - Mid-stream reset discards the step in flight.
// STRUCTURE
//  Shared params include: N_STATES=8, K=4, code generators (v1: 1011, v0: 1111), PM_W default.
//  Also a function returning {v1,v0} for (state,u); the encoder model and this block share it.
//  Sub-module vit_acs_cell (x8, generate loop):
//  - Inputs: pm0, pm1, bm0, bm1.
//  - Outputs: pm_new, dec.
//  - Pure combinational; registers live in the top.
//  Top holds:
//  - BM generation (4 distinct branch outputs).
//  - PM register file.
//  - Normalisation detect.
//  - Min-tree (3 levels, index carried).
//  - Output registers.
// TESTING
//  1 reset held 2 cycles -> out_valid=0, out_dec=8'h00, out_best=0, out_pm_best=0; internal PM={0,16,16,16,16,16,16,16}.
//  2 10 x in_sym=2'b00 after reset -> each step out_valid=1, out_best=0, out_pm_best=0, out_dec[0]=0.
//  3 first symbol after reset 2'b11 -> out_best=4, out_pm_best=0, out_dec[4]=0; state 0 metric = 2.
//  4 encoder-model loopback, 200 random bits, error-free -> out_pm_best=0 every step; offline traceback over out_dec recovers input.
//  5 inject 1 bit error every 8 symbols for 2000 symbols -> out_norm pulses, metrics drop by 32, out_best continuous, no wrap.
//  6 frame_start with in_valid mid-stream, then reset together with frame_start+in_valid -> re-init/ACS as specified; reset wins with out_valid=0.

Source files
------------

// File: rtl/vit_bmu_acs_pkg.sv
// Shared trellis parameters for the K=4 (2,1,3) code.
// Also the branch-label function used by both the encoder and the decoder front end.
package vit_bmu_acs_pkg;

    localparam int N_STATES    = 8;
    localparam int K           = 4;
    localparam logic [3:0] G_V1 = 4'b1011;
    localparam logic [3:0] G_V0 = 4'b1111;
    localparam int PM_W_DEF    = 6;
    localparam int INIT_PM_DEF = 16;

    // Shift register is {u, s[2], s[1], s[0]}; each output is the parity of its generator taps.
    function automatic logic [1:0] branch_out(input logic [2:0] state, input logic u);
        logic [3:0] r;
        r = {u, state};
        return {^(r & G_V1), ^(r & G_V0)};
    endfunction

endpackage

// File: rtl/vit_acs_cell.sv
// Add-compare-select for one next state; ties resolve to predecessor x=0.
module vit_acs_cell #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [PM_W-1:0] bm0,
    input  logic [PM_W-1:0] bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    always_comb begin
        cand0  = pm0 + bm0;
        cand1  = pm1 + bm1;
        dec    = (cand1 < cand0);
        pm_new = dec ? cand1 : cand0;
    end

endmodule

// File: rtl/vit_bmu_acs.sv
// Viterbi branch-metric + ACS stage for the 8-state trellis.
// Produces survivor decisions and the best state each valid step.
module vit_bmu_acs
    import vit_bmu_acs_pkg::*;
#(
    parameter int PM_W    = PM_W_DEF,
    parameter int INIT_PM = INIT_PM_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [1:0]      in_sym,
    input  logic            frame_start,
    output logic            out_valid,
    output logic [7:0]      out_dec,
    output logic [2:0]      out_best,
    output logic [PM_W-1:0] out_pm_best,
    output logic            out_norm
);

    logic [PM_W-1:0]     pm     [N_STATES];
    logic [PM_W-1:0]     pm_eff [N_STATES];
    logic [PM_W-1:0]     pm_sel [N_STATES];
    logic [PM_W-1:0]     pm_nrm [N_STATES];
    logic [1:0]          bm_tab [4];
    logic [N_STATES-1:0] dec;
    logic [N_STATES-1:0] msb;
    logic                norm;

    logic [PM_W-1:0] m1 [4];
    logic [2:0]      i1 [4];
    logic [PM_W-1:0] m2 [2];
    logic [2:0]      i2 [2];
    logic [PM_W-1:0] best_pm;
    logic [2:0]      best_idx;

    // A frame start in the same cycle as a symbol must feed the fresh metrics into ACS.
    always_comb begin
        for (int i = 0; i < N_STATES; i++) begin
            pm_eff[i] = frame_start ? ((i == 0) ? '0 : PM_W'(INIT_PM)) : pm[i];
        end
        for (int l = 0; l < 4; l++) begin
            bm_tab[l] = {1'b0, in_sym[1] ^ l[1]} + {1'b0, in_sym[0] ^ l[0]};
        end
    end

    for (genvar n = 0; n < N_STATES; n++) begin : g_acs
        localparam logic [2:0] NS = 3'(n);
        localparam logic [1:0] L0 = branch_out({NS[1:0], 1'b0}, NS[2]);
        localparam logic [1:0] L1 = branch_out({NS[1:0], 1'b1}, NS[2]);

        vit_acs_cell #(.PM_W(PM_W)) u_cell (
            .pm0    (pm_eff[{NS[1:0], 1'b0}]),
            .pm1    (pm_eff[{NS[1:0], 1'b1}]),
            .bm0    ({{(PM_W-2){1'b0}}, bm_tab[L0]}),
            .bm1    ({{(PM_W-2){1'b0}}, bm_tab[L1]}),
            .pm_new (pm_sel[n]),
            .dec    (dec[n])
        );
    end

    // Once every metric has its MSB set, dropping the MSB subtracts the same amount from all.
    always_comb begin
        for (int i = 0; i < N_STATES; i++) begin
            msb[i] = pm_sel[i][PM_W-1];
        end
        norm = &msb;
        for (int i = 0; i < N_STATES; i++) begin
            pm_nrm[i] = norm ? {1'b0, pm_sel[i][PM_W-2:0]} : pm_sel[i];
        end
    end

    // Three-level min-tree; strict compares keep the lower index on ties.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (pm_nrm[2*k+1] < pm_nrm[2*k]) begin
                m1[k] = pm_nrm[2*k+1];
                i1[k] = 3'(2*k+1);
            end else begin
                m1[k] = pm_nrm[2*k];
                i1[k] = 3'(2*k);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (m1[2*k+1] < m1[2*k]) begin
                m2[k] = m1[2*k+1];
                i2[k] = i1[2*k+1];
            end else begin
                m2[k] = m1[2*k];
                i2[k] = i1[2*k];
            end
        end
        if (m2[1] < m2[0]) begin
            best_pm  = m2[1];
            best_idx = i2[1];
        end else begin
            best_pm  = m2[0];
            best_idx = i2[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_STATES; i++) begin
                pm[i] <= (i == 0) ? '0 : PM_W'(INIT_PM);
            end
            out_valid   <= 1'b0;
            out_dec     <= '0;
            out_best    <= '0;
            out_pm_best <= '0;
            out_norm    <= 1'b0;
        end else begin
            if (in_valid) begin
                for (int i = 0; i < N_STATES; i++) begin
                    pm[i] <= pm_nrm[i];
                end
                out_dec     <= dec;
                out_best    <= best_idx;
                out_pm_best <= best_pm;
            end else if (frame_start) begin
                for (int i = 0; i < N_STATES; i++) begin
                    pm[i] <= (i == 0) ? '0 : PM_W'(INIT_PM);
                end
            end
            out_valid <= in_valid;
            out_norm  <= in_valid & norm;
        end
    end

endmodule

// File: tb/tb_vit_bmu_acs.sv
// Randomised bench for vit_bmu_acs against a forward-trellis reference model.
module tb_vit_bmu_acs;

    localparam int PM_W    = 6;
    localparam int INIT_PM = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [1:0]      in_sym;
    logic            frame_start;
    logic            out_valid;
    logic [7:0]      out_dec;
    logic [2:0]      out_best;
    logic [PM_W-1:0] out_pm_best;
    logic            out_norm;

    int n_compared   = 0;
    int n_mismatched = 0;

    int         pm_m [8];
    logic [7:0] dec_m;
    int         best_m;
    int         pmb_m;
    logic       valid_m;
    logic       norm_m;

    int         enc_s;
    int         norm_count;
    logic [7:0] dec_log  [$];
    int         bits_log [$];

    always #5 clock = ~clock;

    vit_bmu_acs #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sym      (in_sym),
        .frame_start (frame_start),
        .out_valid   (out_valid),
        .out_dec     (out_dec),
        .out_best    (out_best),
        .out_pm_best (out_pm_best),
        .out_norm    (out_norm)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Encoder output for state s and input u, straight from the trellis equations.
    function automatic int encSym(input int s, input int u);
        int s2, s1, s0;
        s2 = (s >> 2) & 1;
        s1 = (s >> 1) & 1;
        s0 = s & 1;
        return ((u ^ s1 ^ s0) << 1) | (u ^ s2 ^ s1 ^ s0);
    endfunction

    task automatic modelInit();
        pm_m[0] = 0;
        for (int i = 1; i < 8; i++) pm_m[i] = INIT_PM;
    endtask

    // Forward pass: every (state, input) branch offers a candidate to its next state.
    task automatic modelStep(input logic [1:0] sym);
        int newpm [8];
        int lbl, bm, c, nxt;
        bit all_high;
        for (int n = 0; n < 8; n++) newpm[n] = 1 << 30;
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                nxt = u * 4 + (s >> 1);
                lbl = encSym(s, u);
                bm  = int'(sym[1] != lbl[1]) + int'(sym[0] != lbl[0]);
                c   = pm_m[s] + bm;
                if (c < newpm[nxt]) begin
                    newpm[nxt] = c;
                    dec_m[nxt] = 1'(s & 1);
                end
            end
        end
        all_high = 1'b1;
        for (int n = 0; n < 8; n++) if (newpm[n] < 32) all_high = 1'b0;
        norm_m = all_high;
        best_m = 0;
        for (int n = 0; n < 8; n++) begin
            pm_m[n] = all_high ? newpm[n] - 32 : newpm[n];
            if (pm_m[n] < pm_m[best_m]) best_m = n;
        end
        pmb_m   = pm_m[best_m];
        valid_m = 1'b1;
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic fs, input logic [1:0] sym);
        @(negedge clock);
        reset       = rst;
        in_valid    = v;
        frame_start = fs;
        in_sym      = sym;
        @(posedge clock);
        #1;
        if (rst) begin
            modelInit();
            valid_m = 1'b0;
            norm_m  = 1'b0;
            dec_m   = '0;
            best_m  = 0;
            pmb_m   = 0;
        end else if (v) begin
            if (fs) modelInit();
            modelStep(sym);
        end else begin
            if (fs) modelInit();
            valid_m = 1'b0;
            norm_m  = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'(valid_m));
        checkOutput({tag, ".dec"}, 32'(out_dec), 32'(dec_m));
        checkOutput({tag, ".best"}, 32'(out_best), 32'(best_m));
        checkOutput({tag, ".pm_best"}, 32'(out_pm_best), 32'(pmb_m));
        checkOutput({tag, ".norm"}, 32'(out_norm), 32'(norm_m));
    endtask

    initial begin
        int u, sym, errs, st;
        reset = 1'b1; in_valid = 1'b0; frame_start = 1'b0; in_sym = 2'b00;

        // Reset held two cycles.
        applyStimulus(1, 0, 0, 2'b00); checkAll("reset0");
        applyStimulus(1, 0, 0, 2'b00); checkAll("reset1");
        checkOutput("reset.dec_const", 32'(out_dec), 32'h00);

        // All-zero symbols keep state 0 at metric 0.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 2'b00); checkAll("zeros");
            checkOutput("zeros.best0", 32'(out_best), 0);
            checkOutput("zeros.pm0", 32'(out_pm_best), 0);
            checkOutput("zeros.dec0", 32'(out_dec[0]), 0);
        end

        // First symbol 11 after reset lands best in state 4.
        applyStimulus(1, 0, 0, 2'b00); checkAll("reset2");
        applyStimulus(0, 1, 0, 2'b11); checkAll("first11");
        checkOutput("first11.best4", 32'(out_best), 4);
        checkOutput("first11.pm0", 32'(out_pm_best), 0);
        checkOutput("first11.dec4", 32'(out_dec[4]), 0);

        // Error-free loopback followed by offline traceback.
        applyStimulus(1, 0, 0, 2'b00); checkAll("reset3");
        enc_s = 0;
        for (int t = 0; t < 200; t++) begin
            u   = int'($urandom_range(0, 1));
            sym = encSym(enc_s, u);
            enc_s = u * 4 + (enc_s >> 1);
            bits_log.push_back(u);
            applyStimulus(0, 1, 0, 2'(sym)); checkAll("loop");
            checkOutput("loop.pm_zero", 32'(out_pm_best), 0);
            dec_log.push_back(out_dec);
        end
        errs = 0;
        st   = int'(out_best);
        for (int t = 199; t >= 0; t--) begin
            if (((st >> 2) & 1) != bits_log[t]) errs++;
            st = ((st & 3) << 1) | int'(dec_log[t][st]);
        end
        checkOutput("loop.traceback_errs", 32'(errs), 0);

        // Long stream with sparse errors, exercising normalisation.
        applyStimulus(1, 0, 0, 2'b00); checkAll("reset4");
        enc_s = 0; norm_count = 0;
        for (int t = 0; t < 2000; t++) begin
            u   = int'($urandom_range(0, 1));
            sym = encSym(enc_s, u);
            enc_s = u * 4 + (enc_s >> 1);
            if ((t % 8) == 7) sym = sym ^ (1 << $urandom_range(0, 1));
            applyStimulus(0, 1, 0, 2'(sym)); checkAll("noisy");
            checkOutput("noisy.no_wrap", 32'(out_pm_best < 32), 1);
            if (out_norm) norm_count++;
        end
        checkOutput("noisy.norm_seen", 32'(norm_count > 0), 1);

        // Random valid gaps, random frame starts, random symbols.
        for (int t = 0; t < 300; t++) begin
            applyStimulus(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                          2'($urandom_range(0, 3)));
            checkAll("random");
        end

        // Frame start with symbol mid-stream, then reset overriding both.
        applyStimulus(0, 1, 1, 2'b10); checkAll("fs_valid");
        applyStimulus(0, 1, 0, 2'b01); checkAll("after_fs");
        applyStimulus(1, 1, 1, 2'b11); checkAll("reset_wins");
        checkOutput("reset_wins.valid0", 32'(out_valid), 0);
        applyStimulus(0, 1, 0, 2'b11); checkAll("after_reset");
        applyStimulus(0, 0, 0, 2'b00); checkAll("idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
